// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with branch redirect, post-branch flush window and halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        beq,
    input  logic        bne,
    input  logic        b,
    input  logic        zero,
    input  logic [31:0] target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        flush,
    output logic        redirect,
    output logic        halted,
    output logic [15:0] taken_cnt
);
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_pc;
    logic        r_flush, r_redirect, r_halted;
    logic [15:0] r_taken_cnt;
    logic        w_taken;
    logic [31:0] w_pc_inc;
    assign w_taken  = b | (beq ? zero : (bne & ~zero));
    assign w_pc_inc = r_pc + 32'd4;
    assign pc        = r_pc;
    assign flush     = r_flush;
    assign redirect  = r_redirect;
    assign halted    = r_halted;
    assign taken_cnt = r_taken_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_cnt       <= 3'd0;
            r_pc        <= RESET_PC;
            r_flush     <= 1'b0;
            r_redirect  <= 1'b0;
            r_halted    <= 1'b0;
            r_taken_cnt <= 16'd0;
        end else begin
            r_redirect <= 1'b0;
            if (!stall) begin
                case (r_state)
                    RUN: begin
                        if (w_taken) begin
                            r_pc        <= {target[31:2], 2'b00};
                            r_cnt       <= 3'(FLUSH_CYCLES - 1);
                            r_state     <= FLUSH;
                            r_flush     <= 1'b1;
                            r_redirect  <= 1'b1;
                            r_taken_cnt <= r_taken_cnt + {15'd0, r_taken_cnt != 16'hFFFF};
                        end else if (halt) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    FLUSH: begin
                        r_pc <= w_pc_inc;
                        if (r_cnt == 3'd0) begin
                            r_state <= RUN;
                            r_flush <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    HALTED: ;
                    default: r_state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus reset, wrap and saturation sequences.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, stall, beq, bne, b, zero, halt;
    logic [31:0] target;
    logic [31:0] pc, pc2;
    logic        flush, redirect, halted, flush2, redirect2, halted2;
    logic [15:0] taken_cnt, taken_cnt2;
    int          n_pass = 0;
    int          n_tot  = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .beq(beq), .bne(bne), .b(b),
        .zero(zero), .target(target), .halt(halt), .pc(pc), .flush(flush),
        .redirect(redirect), .halted(halted), .taken_cnt(taken_cnt)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .beq(beq), .bne(bne), .b(b),
        .zero(zero), .target(target), .halt(halt), .pc(pc2), .flush(flush2),
        .redirect(redirect2), .halted(halted2), .taken_cnt(taken_cnt2)
    );

    typedef struct {
        logic        stall, beq, bne, b, zero, halt;
        logic [31:0] target, pc;
        logic        flush, redirect, halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(logic s, logic q_beq, logic q_bne, logic q_b, logic z, logic h,
                                logic [31:0] t, logic [31:0] p, logic f, logic r, logic hd,
                                logic [15:0] c);
        vec_t v;
        v.stall = s; v.beq = q_beq; v.bne = q_bne; v.b = q_b; v.zero = z; v.halt = h;
        v.target = t; v.pc = p; v.flush = f; v.redirect = r; v.halted = hd; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(logic s, logic q_beq, logic q_bne, logic q_b, logic z, logic h, logic [31:0] t);
        stall = s; beq = q_beq; bne = q_bne; b = q_b; zero = z; halt = h; target = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
        chk("rst_pc2", pc2, 32'hFFFF_FFF8);
        reset = 1'b0;

        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h4,   0,0,0, 16'd0));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h8,   0,0,0, 16'd0));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'hC,   0,0,0, 16'd0));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h10,  0,0,0, 16'd0));
        q.push_back(mk(0,1,0,0,1,0, 32'h43,  32'h40,  1,1,0, 16'd1));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h44,  1,0,0, 16'd1));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h48,  0,0,0, 16'd1));
        q.push_back(mk(0,0,1,0,1,0, 32'h900, 32'h4C,  0,0,0, 16'd1));
        q.push_back(mk(0,1,0,1,0,0, 32'h100, 32'h100, 1,1,0, 16'd2));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h104, 1,0,0, 16'd2));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h108, 0,0,0, 16'd2));
        q.push_back(mk(0,0,0,1,0,0, 32'h200, 32'h200, 1,1,0, 16'd3));
        q.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h200, 1,0,0, 16'd3));
        q.push_back(mk(1,0,0,1,1,0, 32'h500, 32'h200, 1,0,0, 16'd3));
        q.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h200, 1,0,0, 16'd3));
        q.push_back(mk(0,0,0,1,0,0, 32'h300, 32'h204, 1,0,0, 16'd3));
        q.push_back(mk(0,0,0,1,0,0, 32'h300, 32'h208, 0,0,0, 16'd3));
        q.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h208, 0,0,0, 16'd3));
        q.push_back(mk(0,0,0,1,0,1, 32'h402, 32'h400, 1,1,0, 16'd4));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h404, 1,0,0, 16'd4));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h408, 0,0,0, 16'd4));
        q.push_back(mk(0,0,0,0,0,1, 32'h0,   32'h408, 0,0,1, 16'd4));
        q.push_back(mk(0,1,0,1,1,0, 32'h800, 32'h408, 0,0,1, 16'd4));
        q.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h408, 0,0,1, 16'd4));

        foreach (q[i]) begin
            drive(q[i].stall, q[i].beq, q[i].bne, q[i].b, q[i].zero, q[i].halt, q[i].target);
            step();
            chk($sformatf("v%0d_pc", i), pc, q[i].pc);
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, q[i].flush});
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, q[i].redirect});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, q[i].halted});
            chk($sformatf("v%0d_cnt", i), {16'd0, taken_cnt}, {16'd0, q[i].cnt});
        end

        reset = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 32'h700);
        step();
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        chk("halt_rst_cnt", {16'd0, taken_cnt}, 32'd0);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        chk("post_rst_pc", pc, 32'h4);
        step();
        chk("wrap_pc2", pc2, 32'h0000_0000);

        force dut2.r_taken_cnt = 16'hFFFF;
        #1;
        release dut2.r_taken_cnt;
        drive(0, 0, 0, 1, 0, 0, 32'h83);
        step();
        chk("sat_cnt", {16'd0, taken_cnt2}, 32'h0000_FFFF);
        chk("sat_pc", pc2, 32'h80);
        chk("fc1_flush_on", {31'd0, flush2}, 32'd1);
        chk("main_cnt", {16'd0, taken_cnt}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        chk("fc1_flush_off", {31'd0, flush2}, 32'd0);
        chk("fc1_pc", pc2, 32'h84);
        chk("main_flush_mid", {31'd0, flush}, 32'd1);

        reset = 1'b1;
        step();
        chk("flush_rst_flush", {31'd0, flush}, 32'd0);
        chk("flush_rst_pc", pc, 32'h0);
        chk("flush_rst_cnt", {16'd0, taken_cnt}, 32'd0);
        reset = 1'b0;
        step();
        chk("flush_rst_after_pc", pc, 32'h4);
        chk("flush_rst_after_flush", {31'd0, flush}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
